// File: rtl/xbus_arbiter.sv
// XBus rendezvous arbiter: pairs one blocked writer with one blocked reader (never itself),
// round-robin on both sides, moving one saturated word per transfer.

module xbus_rd_pick #(
  parameter int NUM_PORTS = 4,
  parameter int PTR_W     = 2,
  parameter int SELF      = 0
) (
  input  logic [NUM_PORTS-1:0] rd_req,
  input  logic [PTR_W-1:0]     rd_ptr,
  output logic                 hit,
  output logic [PTR_W-1:0]     sel
);
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  // First reader from rd_ptr onward that is not this writer.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    sum = '0;
    idx = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      sum = {1'b0, rd_ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_PORTS)) sum = sum - (PTR_W+1)'(NUM_PORTS);
      idx = sum[PTR_W-1:0];
      if (!hit && rd_req[idx] && (idx != PTR_W'(SELF))) begin
        hit = 1'b1;
        sel = idx;
      end
    end
  end
endmodule

module xbus_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 11,
  parameter int VAL_MAX   = 999
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          wr_req,
  input  logic [NUM_PORTS*DATA_W-1:0]   wr_data,
  input  logic [NUM_PORTS-1:0]          rd_req,
  output logic [NUM_PORTS-1:0]          wr_ack,
  output logic [NUM_PORTS-1:0]          rd_ack,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          busy,
  output logic [15:0]                   xfer_count
);
  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic signed [DATA_W-1:0] VMAX = DATA_W'(VAL_MAX);
  localparam logic signed [DATA_W-1:0] VMIN = -VMAX;

  typedef enum logic [1:0] {IDLE, MATCH, XFER, GAP} state_t;
  state_t state, state_nxt;

  logic [NUM_PORTS-1:0][DATA_W-1:0] wd;
  logic [NUM_PORTS-1:0]             rd_hit;
  logic [NUM_PORTS-1:0][PTR_W-1:0]  rd_sel;
  logic [PTR_W-1:0]                 wr_ptr, rd_ptr, w_sel, r_sel, m_w, m_r;
  logic [PTR_W:0]                   wsum;
  logic [PTR_W-1:0]                 widx;
  logic                             m_found;
  logic signed [DATA_W-1:0]         data_lat, data_clamp;

  assign wd = wr_data;

  // One reader search per candidate writer so self-pairing is excluded per writer.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_pick
    xbus_rd_pick #(.NUM_PORTS(NUM_PORTS), .PTR_W(PTR_W), .SELF(i)) u_pick (
      .rd_req (rd_req),
      .rd_ptr (rd_ptr),
      .hit    (rd_hit[i]),
      .sel    (rd_sel[i])
    );
  end

  always_comb begin
    m_found = 1'b0;
    m_w     = '0;
    m_r     = '0;
    wsum    = '0;
    widx    = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      wsum = {1'b0, wr_ptr} + (PTR_W+1)'(k);
      if (wsum >= (PTR_W+1)'(NUM_PORTS)) wsum = wsum - (PTR_W+1)'(NUM_PORTS);
      widx = wsum[PTR_W-1:0];
      if (!m_found && wr_req[widx] && rd_hit[widx]) begin
        m_found = 1'b1;
        m_w     = widx;
        m_r     = rd_sel[widx];
      end
    end
  end

  always_comb begin
    data_clamp = data_lat;
    if (data_lat > VMAX)      data_clamp = VMAX;
    else if (data_lat < VMIN) data_clamp = VMIN;
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(NUM_PORTS-1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    state_nxt = state;
    wr_ack    = '0;
    rd_ack    = '0;
    busy      = 1'b0;
    case (state)
      IDLE:  if (m_found) state_nxt = MATCH;
      MATCH: begin
        busy      = 1'b1;
        state_nxt = XFER;
      end
      XFER: begin
        busy          = 1'b1;
        wr_ack[w_sel] = 1'b1;
        rd_ack[r_sel] = 1'b1;
        state_nxt     = GAP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      w_sel      <= '0;
      r_sel      <= '0;
      data_lat   <= '0;
      rd_data    <= '0;
      xfer_count <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (m_found) begin
          w_sel    <= m_w;
          r_sel    <= m_r;
          data_lat <= wd[m_w];
        end
        MATCH: rd_data <= data_clamp;
        XFER: begin
          wr_ptr     <= ptr_inc(w_sel);
          rd_ptr     <= ptr_inc(r_sel);
          xfer_count <= xfer_count + 16'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_xbus_arbiter.sv
// Directed bench for xbus_arbiter: reset, basic pairing, self-pair block, fairness,
// saturation and transfer counter wrap.

module tb_xbus_arbiter;
  localparam int NP = 4;
  localparam int DW = 11;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    wr_req, rd_req, wr_ack, rd_ack;
  logic [NP*DW-1:0] wr_data;
  logic [DW-1:0]    rd_data;
  logic             busy;
  logic [15:0]      xfer_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xbus_arbiter #(.NUM_PORTS(NP), .DATA_W(DW), .VAL_MAX(999)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_req     (wr_req),
    .wr_data    (wr_data),
    .rd_req     (rd_req),
    .wr_ack     (wr_ack),
    .rd_ack     (rd_ack),
    .rd_data    (rd_data),
    .busy       (busy),
    .xfer_count (xfer_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the ack cycle, then check acks and transferred word.
  task automatic xfer(input string tag, input logic [31:0] ew, input logic [31:0] er,
                      input logic [31:0] ed);
    bit seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (wr_ack != '0) seen = 1;
    end
    chk({tag, "_ack_seen"}, 32'(seen), 32'd1);
    chk({tag, "_wr_ack"}, 32'(wr_ack), ew);
    chk({tag, "_rd_ack"}, 32'(rd_ack), er);
    chk({tag, "_rd_data"}, 32'(rd_data), ed);
  endtask

  initial begin
    rst = 1'b1; wr_req = '0; rd_req = '0; wr_data = '0;
    @(negedge clk);
    chk("rst_acks", 32'({wr_ack, rd_ack}), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_count", 32'(xfer_count), 32'h0);
    chk("rst_data", 32'(rd_data), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Basic: writer 0 -> reader 2, acks two cycles after the match
    wr_req = 4'b0001; wr_data[0*DW +: DW] = 11'd42; rd_req = 4'b0100;
    @(negedge clk);
    chk("basic_match_busy", 32'(busy), 32'h1);
    chk("basic_match_noack", 32'({wr_ack, rd_ack}), 32'h0);
    @(negedge clk);
    chk("basic_wr_ack", 32'(wr_ack), 32'h1);
    chk("basic_rd_ack", 32'(rd_ack), 32'h4);
    chk("basic_rd_data", 32'(rd_data), 32'd42);
    wr_req = '0; rd_req = '0;
    @(negedge clk);
    chk("basic_gap_noack", 32'({wr_ack, rd_ack}), 32'h0);
    chk("basic_count", 32'(xfer_count), 32'd1);
    chk("basic_data_hold", 32'(rd_data), 32'd42);

    // Self pairing: core 1 alone can never complete
    wr_req = 4'b0010; rd_req = 4'b0010; wr_data[1*DW +: DW] = 11'd9;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("self_idle", 32'({wr_ack, rd_ack, busy}), 32'h0);
    end
    wr_req = '0; rd_req = '0;
    @(negedge clk);

    // Reset asserted while acks are up
    wr_req = 4'b0010; wr_data[1*DW +: DW] = 11'd100; rd_req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_pre_ack", 32'(wr_ack), 32'h2);
    rst = 1'b1;
    #1;
    chk("midrst_acks", 32'({wr_ack, rd_ack}), 32'h0);
    chk("midrst_data", 32'(rd_data), 32'h0);
    chk("midrst_count", 32'(xfer_count), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    wr_req = '0; rd_req = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Fairness: writers 0,1,2 continuously, reader 3 continuously
    wr_data[0*DW +: DW] = 11'd5; wr_data[1*DW +: DW] = 11'd6; wr_data[2*DW +: DW] = 11'd7;
    wr_req = 4'b0111; rd_req = 4'b1000;
    xfer("fair0", 32'h1, 32'h8, 32'd5);
    xfer("fair1", 32'h2, 32'h8, 32'd6);
    xfer("fair2", 32'h4, 32'h8, 32'd7);
    xfer("fair3", 32'h1, 32'h8, 32'd5);
    wr_req = '0; rd_req = '0;
    @(negedge clk);
    chk("fair_count", 32'(xfer_count), 32'd4);
    @(negedge clk);

    // Saturation and pass-through of an in-range negative word
    wr_data[0*DW +: DW] = 11'h3FF; wr_req = 4'b0001; rd_req = 4'b0010;
    xfer("sat_pos", 32'h1, 32'h2, 32'd999);
    wr_req = '0; rd_req = '0;
    @(negedge clk);
    wr_data[2*DW +: DW] = 11'h400; wr_req = 4'b0100; rd_req = 4'b0001;
    xfer("sat_neg", 32'h4, 32'h1, 32'h419);
    wr_req = '0; rd_req = '0;
    @(negedge clk);
    wr_data[3*DW +: DW] = 11'h7F9; wr_req = 4'b1000; rd_req = 4'b0100;
    xfer("neg_pass", 32'h8, 32'h4, 32'h7F9);
    wr_req = '0; rd_req = '0;
    @(negedge clk);
    @(negedge clk);

    // Counter wrap
    force dut.xfer_count = 16'hFFFF;
    @(negedge clk);
    release dut.xfer_count;
    @(negedge clk);
    chk("wrap_preload", 32'(xfer_count), 32'hFFFF);
    wr_data[1*DW +: DW] = 11'd3; wr_req = 4'b0010; rd_req = 4'b1000;
    xfer("wrap", 32'h2, 32'h8, 32'd3);
    wr_req = '0; rd_req = '0;
    @(negedge clk);
    chk("wrap_count", 32'(xfer_count), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
